nim_matrix_driver: RTL and testbench

//  Downstream display stage of the Nim game top. It takes the four pile stick counts,
//  the selected-row cursor and the game-over flag, and renders them into an 8x8 bitmap.
//  It scans that bitmap column by column through the external 8-bit serial-in shift

---
 rtl/nim_pkg.sv | 26 ++
 rtl/nim_matrix_driver_if.sv | 34 +++
 rtl/nim_frame_builder.sv | 39 +++
 rtl/nim_matrix_driver.sv | 175 +++++++++++++++++
 tb/tb_nim_matrix_driver.sv | 258 +++++++++++++++++++++++++
 5 files changed

// File: rtl/nim_pkg.sv
// Shared types and sizes for the Nim display path.
package nim_pkg;

  localparam int unsigned N_PILES = 4;
  localparam int unsigned MAT_DIM = 8;
  localparam int unsigned COL_W   = $clog2(MAT_DIM);

  typedef logic [2:0] stick_cnt_t;

  typedef enum logic [2:0] {
    SRRST,
    LOAD,
    SHIFT,
    LATCH,
    SHOW
  } drv_state_t;

  // Everything the bitmap is rendered from; held as a shadow copy per frame.
  typedef struct packed {
    stick_cnt_t [N_PILES-1:0] sticks;
    logic [1:0]               sel_row;
    logic                     sel_valid;
    logic                     game_over;
  } frame_cfg_t;

endpackage

// File: rtl/nim_matrix_driver_if.sv
// Game-state inputs and shift-register/column outputs of the matrix driver.
interface nim_matrix_driver_if;
  import nim_pkg::*;

  stick_cnt_t         row1_sticks;
  stick_cnt_t         row2_sticks;
  stick_cnt_t         row3_sticks;
  stick_cnt_t         row4_sticks;
  logic [1:0]         sel_row;
  logic               sel_valid;
  logic               game_over;
  logic               upd;

  logic               reset_out;
  logic               OE;
  logic               SH_CP;
  logic               ST_CP;
  logic               DS;
  logic [MAT_DIM-1:0] col_select;
  logic               frame_done;

  modport master (
    output row1_sticks, row2_sticks, row3_sticks, row4_sticks,
    output sel_row, sel_valid, game_over, upd,
    input  reset_out, OE, SH_CP, ST_CP, DS, col_select, frame_done
  );

  modport slave (
    input  row1_sticks, row2_sticks, row3_sticks, row4_sticks,
    input  sel_row, sel_valid, game_over, upd,
    output reset_out, OE, SH_CP, ST_CP, DS, col_select, frame_done
  );

endinterface

// File: rtl/nim_frame_builder.sv
// Renders the frame configuration into an 8x8 bitmap and returns one column.
module nim_frame_builder
  import nim_pkg::*;
(
  input  frame_cfg_t         cfg_i,
  input  logic [COL_W-1:0]   col_i,
  output logic [MAT_DIM-1:0] col_byte_c
);

  logic [MAT_DIM-1:0][MAT_DIM-1:0] bitmap; // [row][col]

  // Piles on odd rows, cursor in the last column; game over replaces everything.
  always_comb begin
    bitmap = '0;
    for (int k = 0; k < int'(N_PILES); k++) begin
      for (int c = 0; c < int'(MAT_DIM); c++) begin
        bitmap[2*k+1][c] = (4'(c) < {1'b0, cfg_i.sticks[k]});
      end
    end
    if (cfg_i.sel_valid) begin
      bitmap[{cfg_i.sel_row, 1'b1}][MAT_DIM-1] = 1'b1;
    end
    if (cfg_i.game_over) begin
      for (int r = 0; r < int'(MAT_DIM); r++) begin
        for (int c = 0; c < int'(MAT_DIM); c++) begin
          bitmap[r][c] = ((r + c) % 2) == 1;
        end
      end
    end
  end

  always_comb begin
    col_byte_c = '0;
    for (int r = 0; r < int'(MAT_DIM); r++) begin
      col_byte_c[r] = bitmap[r][col_i];
    end
  end

endmodule

// File: rtl/nim_matrix_driver.sv
// Column-scanning driver for an 8x8 matrix behind a serial-in shift register.
module nim_matrix_driver
  import nim_pkg::*;
#(
  parameter int unsigned CLK_DIV    = 4,
  parameter int unsigned COL_HOLD   = 2000,
  parameter int unsigned SR_RST_CYC = 4
) (
  input  logic                clk,
  input  logic                rst,
  nim_matrix_driver_if.slave  bus
);

  localparam int unsigned MAX_A   = (SR_RST_CYC > 2 * CLK_DIV) ? SR_RST_CYC : 2 * CLK_DIV;
  localparam int unsigned MAX_CNT = (MAX_A > COL_HOLD) ? MAX_A : COL_HOLD;
  localparam int unsigned CNT_W   = $clog2(MAX_CNT + 1);

  drv_state_t         state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [2:0]         bit_q, bit_d;
  logic [COL_W-1:0]   col_q, col_d;
  logic [MAT_DIM-1:0] byte_q, byte_d;
  frame_cfg_t         shadow_q, shadow_d, live_cfg;
  logic               upd_pending_q, upd_pending_d;
  logic               reset_out_q, reset_out_d;
  logic               oe_q, oe_d;
  logic               sh_cp_q, sh_cp_d;
  logic               st_cp_q, st_cp_d;
  logic               ds_q, ds_d;
  logic [MAT_DIM-1:0] col_sel_q, col_sel_d;
  logic               frame_done_q, frame_done_d;
  logic               capture_c;
  logic [MAT_DIM-1:0] col_byte_c;

  always_comb begin
    live_cfg           = '0;
    live_cfg.sticks    = {bus.row4_sticks, bus.row3_sticks, bus.row2_sticks, bus.row1_sticks};
    live_cfg.sel_row   = bus.sel_row;
    live_cfg.sel_valid = bus.sel_valid;
    live_cfg.game_over = bus.game_over;
  end

  // Snapshots happen only at the column-0 load, so a frame is never torn.
  assign capture_c     = (state_q == LOAD) && (col_q == '0) && (upd_pending_q || bus.upd);
  assign shadow_d      = capture_c ? live_cfg : shadow_q;
  assign upd_pending_d = capture_c ? 1'b0 : (upd_pending_q | bus.upd);

  // Built from the post-capture shadow so a column-0 update shows immediately.
  nim_frame_builder u_builder (
    .cfg_i      (shadow_d),
    .col_i      (col_q),
    .col_byte_c (col_byte_c)
  );

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q + CNT_W'(1);
    bit_d        = bit_q;
    col_d        = col_q;
    byte_d       = byte_q;
    reset_out_d  = reset_out_q;
    oe_d         = oe_q;
    sh_cp_d      = sh_cp_q;
    st_cp_d      = st_cp_q;
    ds_d         = ds_q;
    col_sel_d    = col_sel_q;
    frame_done_d = 1'b0;

    unique case (state_q)
      SRRST: begin
        reset_out_d = 1'b0;
        oe_d        = 1'b1;
        if (cnt_q == CNT_W'(SR_RST_CYC - 1)) begin
          state_d     = LOAD;
          cnt_d       = '0;
          col_d       = '0;
          reset_out_d = 1'b1;
        end
      end
      LOAD: begin
        state_d = SHIFT;
        cnt_d   = '0;
        bit_d   = '0;
        byte_d  = col_byte_c;
        ds_d    = col_byte_c[MAT_DIM-1];
        sh_cp_d = 1'b0;
      end
      SHIFT: begin
        if (cnt_q == CNT_W'(CLK_DIV - 1)) begin
          sh_cp_d = 1'b1;
        end
        // Bit boundary: the falling SH_CP edge and the next DS change coincide.
        if (cnt_q == CNT_W'(2 * CLK_DIV - 1)) begin
          cnt_d   = '0;
          sh_cp_d = 1'b0;
          if (bit_q == 3'd7) begin
            state_d = LATCH;
            st_cp_d = 1'b1;
            ds_d    = 1'b0;
          end else begin
            bit_d  = bit_q + 3'd1;
            byte_d = {byte_q[MAT_DIM-2:0], 1'b0};
            ds_d   = byte_q[MAT_DIM-2];
          end
        end
      end
      LATCH: begin
        if (cnt_q == CNT_W'(CLK_DIV - 1)) begin
          state_d   = SHOW;
          cnt_d     = '0;
          st_cp_d   = 1'b0;
          oe_d      = 1'b0;
          col_sel_d = MAT_DIM'(1) << col_q;
        end
      end
      SHOW: begin
        if (cnt_q == CNT_W'(COL_HOLD - 1)) begin
          state_d      = LOAD;
          cnt_d        = '0;
          oe_d         = 1'b1;
          col_sel_d    = '0;
          col_d        = col_q + COL_W'(1);
          frame_done_d = (col_q == COL_W'(MAT_DIM - 1));
        end
      end
      default: begin
        state_d = SRRST;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= SRRST;
      cnt_q         <= '0;
      bit_q         <= '0;
      col_q         <= '0;
      byte_q        <= '0;
      shadow_q      <= '0;
      upd_pending_q <= 1'b0;
      reset_out_q   <= 1'b0;
      oe_q          <= 1'b1;
      sh_cp_q       <= 1'b0;
      st_cp_q       <= 1'b0;
      ds_q          <= 1'b0;
      col_sel_q     <= '0;
      frame_done_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      bit_q         <= bit_d;
      col_q         <= col_d;
      byte_q        <= byte_d;
      shadow_q      <= shadow_d;
      upd_pending_q <= upd_pending_d;
      reset_out_q   <= reset_out_d;
      oe_q          <= oe_d;
      sh_cp_q       <= sh_cp_d;
      st_cp_q       <= st_cp_d;
      ds_q          <= ds_d;
      col_sel_q     <= col_sel_d;
      frame_done_q  <= frame_done_d;
    end
  end

  assign bus.reset_out  = reset_out_q;
  assign bus.OE         = oe_q;
  assign bus.SH_CP      = sh_cp_q;
  assign bus.ST_CP      = st_cp_q;
  assign bus.DS         = ds_q;
  assign bus.col_select = col_sel_q;
  assign bus.frame_done = frame_done_q;

endmodule

// File: tb/tb_nim_matrix_driver.sv
// Directed bench for nim_matrix_driver: scoreboarded column bytes plus scan timing.
module tb_nim_matrix_driver;
  import nim_pkg::*;

  localparam int unsigned CLK_DIV    = 2;
  localparam int unsigned COL_HOLD   = 10;
  localparam int unsigned SR_RST_CYC = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  nim_matrix_driver_if bus ();

  nim_matrix_driver #(
    .CLK_DIV    (CLK_DIV),
    .COL_HOLD   (COL_HOLD),
    .SR_RST_CYC (SR_RST_CYC)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    int         col;
    logic [7:0] bits;
  } exp_t;

  exp_t exp_q[$];
  int   n_pass = 0;
  int   n_fail = 0;
  int   n_total = 0;

  // Bench-side copies: live values driven, and the snapshot the DUT should display.
  int l_cnt[4];
  int l_sel;
  bit l_sv, l_go;
  int m_cnt[4];
  int m_sel;
  bit m_sv, m_go;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_total++;
    assert (obs === expv) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic logic [7:0] model_col(input int col);
    logic [7:0] b;
    int         p;
    b = '0;
    for (int r = 0; r < 8; r++) begin
      if (m_go) begin
        b[r] = ((r + col) % 2) == 1;
      end else if ((r % 2) == 1) begin
        p    = r / 2;
        b[r] = (col < m_cnt[p]) || (m_sv && (m_sel == p) && (col == 7));
      end
    end
    return b;
  endfunction

  task automatic drive_inputs(input int c0, input int c1, input int c2, input int c3,
                              input int sel, input bit sv, input bit go);
    l_cnt[0] = c0; l_cnt[1] = c1; l_cnt[2] = c2; l_cnt[3] = c3;
    l_sel = sel; l_sv = sv; l_go = go;
    bus.row1_sticks = 3'(c0);
    bus.row2_sticks = 3'(c1);
    bus.row3_sticks = 3'(c2);
    bus.row4_sticks = 3'(c3);
    bus.sel_row     = 2'(sel);
    bus.sel_valid   = sv;
    bus.game_over   = go;
  endtask

  task automatic pulse_upd();
    bus.upd = 1'b1;
    for (int i = 0; i < 4; i++) m_cnt[i] = l_cnt[i];
    m_sel = l_sel; m_sv = l_sv; m_go = l_go;
    @(negedge clk);
    bus.upd = 1'b0;
  endtask

  task automatic push_frame();
    for (int c = 0; c < 8; c++) exp_q.push_back('{col: c, bits: model_col(c)});
  endtask

  // Observes one full column, starting in the blanking phase, until OE rises again.
  task automatic capture_column(output logic [7:0] bits, output logic [7:0] cs,
                                output int sh_rises, output int st_w, output int oe_low,
                                output int blank_err, output logic fd_end, output bit timeout);
    logic prev_sh;
    prev_sh = 1'b0;
    bits = '0; cs = '0; sh_rises = 0; st_w = 0; oe_low = 0; blank_err = 0;
    fd_end = 1'b0; timeout = 1'b1;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (bus.SH_CP !== prev_sh) begin
        if (bus.OE !== 1'b1 || bus.col_select !== 8'h00) blank_err++;
        if (bus.SH_CP === 1'b1) begin
          sh_rises++;
          bits = {bits[6:0], bus.DS};
        end
      end
      prev_sh = bus.SH_CP;
      if (bus.ST_CP === 1'b1) st_w++;
      if (bus.OE === 1'b0) begin
        oe_low++;
        cs = bus.col_select;
      end else if (oe_low > 0) begin
        fd_end  = bus.frame_done;
        timeout = 1'b0;
        break;
      end
    end
  endtask

  task automatic check_one_column(input bit last);
    logic [7:0] bits, cs;
    int         sh_rises, st_w, oe_low, blank_err;
    logic       fd_end;
    bit         timeout;
    exp_t       e;
    capture_column(bits, cs, sh_rises, st_w, oe_low, blank_err, fd_end, timeout);
    check("col_timeout", 32'(timeout), 0);
    if (exp_q.size() == 0) begin
      check("scoreboard_empty", 1, 0);
    end else begin
      e = exp_q.pop_front();
      check($sformatf("col%0d_bits", e.col), 32'(bits), 32'(e.bits));
      check($sformatf("col%0d_select", e.col), 32'(cs), 32'(8'h01 << e.col));
    end
    check("sh_rises", sh_rises, 8);
    check("st_width", st_w, CLK_DIV);
    check("oe_low", oe_low, COL_HOLD);
    check("blank_on_toggle", blank_err, 0);
    check("frame_done", 32'(fd_end), 32'(last));
  endtask

  task automatic scan_frame();
    for (int c = 0; c < 8; c++) check_one_column(c == 7);
  endtask

  task automatic wait_frame_done();
    bit found;
    found = 1'b0;
    for (int n = 0; n < 800; n++) begin
      @(negedge clk);
      if (bus.frame_done === 1'b1) begin
        found = 1'b1;
        break;
      end
    end
    check("frame_done_seen", 32'(found), 1);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_reset_out"}, 32'(bus.reset_out), 0);
    check({tag, "_OE"}, 32'(bus.OE), 1);
    check({tag, "_SH_CP"}, 32'(bus.SH_CP), 0);
    check({tag, "_ST_CP"}, 32'(bus.ST_CP), 0);
    check({tag, "_DS"}, 32'(bus.DS), 0);
    check({tag, "_col_select"}, 32'(bus.col_select), 0);
    check({tag, "_frame_done"}, 32'(bus.frame_done), 0);
  endtask

  // Releases reset on a falling edge and counts clocks until reset_out rises.
  task automatic release_and_count();
    int n;
    rst = 1'b1;
    n   = 0;
    while (bus.reset_out !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("reset_out_delay", n, SR_RST_CYC);
    for (int i = 0; i < 4; i++) m_cnt[i] = 0;
    m_sel = 0; m_sv = 1'b0; m_go = 1'b0;
  endtask

  initial begin
    bit seen_sh;
    rst     = 1'b0;
    bus.upd = 1'b0;
    drive_inputs(0, 0, 0, 0, 0, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    check_reset_values("rst_hold");

    // Bring-up: reset release timing, then one all-dark column with full scan timing.
    release_and_count();
    push_frame();
    check_one_column(1'b0);
    exp_q.delete();

    // Pile counts 1,3,5,7 requested mid-frame, shown from the next frame.
    drive_inputs(1, 3, 5, 7, 0, 1'b0, 1'b0);
    pulse_upd();
    wait_frame_done();
    push_frame();
    scan_frame();

    // Cursor on pile 2, requested in the column-0 load cycle itself.
    drive_inputs(1, 3, 5, 7, 2, 1'b1, 1'b0);
    pulse_upd();
    push_frame();
    scan_frame();

    // Game-over checkerboard overrides piles and cursor.
    drive_inputs(1, 3, 5, 7, 2, 1'b1, 1'b1);
    pulse_upd();
    wait_frame_done();
    push_frame();
    scan_frame();

    // Update during column 3 must not tear the frame in progress.
    push_frame();
    for (int c = 0; c < 3; c++) check_one_column(1'b0);
    drive_inputs(7, 0, 2, 4, 1, 1'b0, 1'b0);
    pulse_upd();
    check_one_column(1'b0);
    check_one_column(1'b0);
    pulse_upd();
    for (int c = 5; c < 8; c++) check_one_column(c == 7);
    push_frame();
    scan_frame();

    // Two strobes gave one capture: later live changes without upd stay invisible.
    drive_inputs(0, 0, 0, 0, 3, 1'b1, 1'b1);
    push_frame();
    scan_frame();

    // Reset in the middle of a shift.
    seen_sh = 1'b0;
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      if (bus.SH_CP === 1'b1) begin
        seen_sh = 1'b1;
        break;
      end
    end
    check("mid_shift_reached", 32'(seen_sh), 1);
    rst = 1'b0;
    #1;
    check_reset_values("rst_mid");
    repeat (2) @(negedge clk);
    release_and_count();
    push_frame();
    check_one_column(1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
